// File: rtl/cla_pkg.sv
// Shared types and the second-level lookahead function for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GRP_W    = 4;
    localparam int CLA_MAX_GRPS = 32;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    typedef struct packed {
        logic [CLA_MAX_GRPS-1:0] c;
        grp_pg_t                 blk;
    } lca_res_t;

    // Sum-of-products carry into every group, so no group waits on its neighbour's carry.
    function automatic lca_res_t lca_carries(
        input logic [CLA_MAX_GRPS-1:0] p,
        input logic [CLA_MAX_GRPS-1:0] g,
        input logic                    cin
    );
        lca_res_t res;
        logic     acc;
        logic     pp;
        for (int i = 0; i < CLA_MAX_GRPS; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            res.c[i] = acc | (pp & cin);
        end
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = CLA_MAX_GRPS - 1; j >= 0; j--) begin
            acc = acc | (g[j] & pp);
            pp  = pp & p[j];
        end
        res.blk.p = pp;
        res.blk.g = acc;
        return res;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: local sum from an externally supplied carry, plus group propagate/generate.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);
    logic [3:0] pb_s;
    logic [3:0] gb_s;
    logic [3:0] c_s;

    assign pb_s   = a ^ b;
    assign gb_s   = a & b;
    assign c_s[0] = cin;
    assign c_s[1] = gb_s[0] | (pb_s[0] & cin);
    assign c_s[2] = gb_s[1] | (pb_s[1] & gb_s[0]) | (pb_s[1] & pb_s[0] & cin);
    assign c_s[3] = gb_s[2] | (pb_s[2] & gb_s[1]) | (pb_s[2] & pb_s[1] & gb_s[0])
                  | (pb_s[2] & pb_s[1] & pb_s[0] & cin);
    assign sum    = pb_s ^ c_s;
    assign p      = &pb_s;
    assign g      = gb_s[3] | (pb_s[3] & gb_s[2]) | (pb_s[3] & pb_s[2] & gb_s[1])
                  | (pb_s[3] & pb_s[2] & pb_s[1] & gb_s[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract: STAGES register slices of 4-bit groups, carry registered between slices.
// Define CLA_PIPE_FLAGS_EN to add registered signed-overflow (ovf) and zero-result (zero) outputs.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int SW  = WIDTH / STAGES;
    localparam int NG  = SW / CLA_GRP_W;
    localparam int LST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH / CLA_GRP_W) || ((WIDTH % (CLA_GRP_W * STAGES)) != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES and 1 <= STAGES <= WIDTH/4");
    end
    if (NG > CLA_MAX_GRPS) begin : g_bad_slice
        $error("cla_pipe_adder: slice wider than the lookahead function supports");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;
    assign b_eff_s  = sub ? ~b : b;
    assign c0_s     = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SW;

        logic [RW-1:0]           a_rem_s;
        logic [RW-1:0]           b_rem_s;
        logic                    c_in_s;
        logic                    vld_in_s;
        logic [NG-1:0]           grp_p_s;
        logic [NG-1:0]           grp_g_s;
        logic [NG-1:0]           grp_c_s;
        logic [CLA_MAX_GRPS-1:0] p_pad_s;
        logic [CLA_MAX_GRPS-1:0] g_pad_s;
        logic                    blk_p_s;
        logic                    blk_g_s;
        logic [SW-1:0]           sum_sl_s;
        logic [(k+1)*SW-1:0]     sum_d;
        logic [(k+1)*SW-1:0]     sum_q;
        logic                    c_d;
        logic                    c_q;
        logic                    vld_q;

        if (k == 0) begin : g_src
            assign a_rem_s  = a;
            assign b_rem_s  = b_eff_s;
            assign c_in_s   = c0_s;
            assign vld_in_s = in_valid;
            assign sum_d    = sum_sl_s;
        end else begin : g_src
            assign a_rem_s  = g_st[k-1].g_ops.a_q;
            assign b_rem_s  = g_st[k-1].g_ops.b_q;
            assign c_in_s   = g_st[k-1].c_q;
            assign vld_in_s = g_st[k-1].vld_q;
            assign sum_d    = {sum_sl_s, g_st[k-1].sum_q};
        end

        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            cla_group4 u_grp (
                .a   (a_rem_s[gi*CLA_GRP_W +: CLA_GRP_W]),
                .b   (b_rem_s[gi*CLA_GRP_W +: CLA_GRP_W]),
                .cin (grp_c_s[gi]),
                .sum (sum_sl_s[gi*CLA_GRP_W +: CLA_GRP_W]),
                .p   (grp_p_s[gi]),
                .g   (grp_g_s[gi])
            );
        end

        // Unused lookahead positions are pass-through groups (p=1, g=0) so block P/G stays exact.
        always_comb begin
            p_pad_s          = '1;
            g_pad_s          = '0;
            p_pad_s[NG-1:0]  = grp_p_s;
            g_pad_s[NG-1:0]  = grp_g_s;
        end

        assign {grp_c_s, blk_p_s, blk_g_s} = (NG + 2)'(lca_carries(p_pad_s, g_pad_s, c_in_s));
        assign c_d = blk_g_s | (blk_p_s & c_in_s);

        // Slice result, carry and valid advance together whenever the pipe moves.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv_s) begin
                vld_q <= vld_in_s;
                c_q   <= c_d;
                sum_q <= sum_d;
            end
        end

        if (k < LST) begin : g_ops
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;

            // Operand bits not yet added travel with the beat to the next slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_s) begin
                    a_q <= a_rem_s[RW-1:SW];
                    b_q <= b_rem_s[RW-1:SW];
                end
            end
        end
    end

    assign out_valid = g_st[LST].vld_q;
    assign sum       = g_st[LST].sum_q;
    assign cout      = g_st[LST].c_q;

`ifdef CLA_PIPE_FLAGS_EN
    logic a_msb_s;
    logic b_msb_s;
    logic s_msb_s;
    logic ovf_d;
    logic zero_d;
    logic ovf_q;
    logic zero_q;

    assign a_msb_s = g_st[LST].a_rem_s[SW-1];
    assign b_msb_s = g_st[LST].b_rem_s[SW-1];
    assign s_msb_s = g_st[LST].sum_sl_s[SW-1];
    assign ovf_d   = (a_msb_s == b_msb_s) & (s_msb_s != a_msb_s);
    assign zero_d  = (g_st[LST].sum_d == '0);

    // Flags are computed in the final slice and registered alongside the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv_s) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=32, STAGES=2); expected results are queued on acceptance.
// Flag outputs are also checked when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;
    localparam int W = 32;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic         ovf;
    logic         zero;
`endif

    exp_t         sb[$];
    logic [S-1:0] m_vld = '0;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        exp_t        e;
        logic [W:0]  t;
        longint      sx;
        longint      sy;
        longint      r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            t = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
            r = sx - sy;
        end else begin
            t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r = sx + sy + longint'(c);
        end
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (t[W-1:0] == '0);
        return e;
    endfunction

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check the held output, then check out_valid after the next edge.
    task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input logic ordy);
        exp_t e;
        logic adv;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        adv = ~m_vld[S-1] | ordy;
        chk_b("in_ready", in_ready, adv);
        if (m_vld[S-1]) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL scoreboard_underflow: observed empty queue expected a pending result");
            end else begin
                e = sb[0];
                chk_w("sum", sum, e.sum);
                chk_b("cout", cout, e.cout);
`ifdef CLA_PIPE_FLAGS_EN
                chk_b("ovf", ovf, e.ovf);
                chk_b("zero", zero, e.zero);
`endif
                if (ordy) void'(sb.pop_front());
            end
        end
        if (adv) begin
            m_vld = {m_vld[S-2:0], iv};
            if (iv) sb.push_back(model(ia, ib, ic, is));
        end
        @(negedge clk);
        chk_b("out_valid", out_valid, m_vld[S-1]);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        m_vld = '0;
        sb.delete();
        #1;
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_w("rst_sum", sum, 32'h0);
        chk_b("rst_cout", cout, 1'b0);
        chk_b("rst_in_ready", in_ready, 1'b1);
`ifdef CLA_PIPE_FLAGS_EN
        chk_b("rst_ovf", ovf, 1'b0);
        chk_b("rst_zero", zero, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();

        // Carry ripples out of the low slice into the high slice.
        cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Subtraction with and without borrow; cin must be ignored when sub=1.
        cyc(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Eight back-to-back beats.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
        idle(2);

        // Full pipe held for five cycles, then released.
        cyc(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Reset with two beats in flight discards both.
        cyc(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        do_reset();
        idle(3);

        // Flag boundaries: signed overflow on add and sub, zero on equal operands.
        cyc(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Random bubbles and backpressure.
        for (int i = 0; i < 24; i++)
            cyc(1'($urandom_range(1, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        idle(4);

        chk_w("sb_drained", W'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
